// File: rtl/gpio_trig_pkg.sv
// Shared definitions for the GPIO trigger sequencer.
//   - trig_state_t : sequencer state encoding (3 bits, IDLE..HOLD)
//   - DEF_*        : default widths used as parameter defaults
package gpio_trig_pkg;

    localparam int DEF_GPIO_DATA_WIDTH = 16;
    localparam int DEF_DELAY_WIDTH     = 32;
    localparam int DEF_PW_WIDTH        = 16;
    localparam int DEF_SYNC_STAGES     = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_PULSE = 3'd3,
        ST_HOLD  = 3'd4
    } trig_state_t;

endpackage

// File: rtl/gpio_edge_detect.sv
// GPIO input bank: input-only pad buffers, per-pin synchroniser and edge
// vector generation.
//   aclk, aresetn : clock, async active-low reset
//   gpio_data     : GPIO pins, never driven (output enable held off)
//   cfg_falling   : 0 = report rising edges, 1 = report falling edges
//   edge_vec      : one bit per pin, high for one cycle on a selected edge
module gpio_edge_detect
    import gpio_trig_pkg::*;
#(
    parameter int GPIO_DATA_WIDTH = DEF_GPIO_DATA_WIDTH,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    inout  wire  [GPIO_DATA_WIDTH-1:0] gpio_data,
    input  logic                       cfg_falling,
    output logic [GPIO_DATA_WIDTH-1:0] edge_vec
);

    logic [GPIO_DATA_WIDTH-1:0]                  pin_in;
    logic [SYNC_STAGES-1:0][GPIO_DATA_WIDTH-1:0] sync_q;
    logic [GPIO_DATA_WIDTH-1:0]                  prev_q;
    logic [GPIO_DATA_WIDTH-1:0]                  cur;

    // Pads are input-only: the bus is observed, never driven.
    assign pin_in = gpio_data;
    assign cur    = sync_q[SYNC_STAGES-1];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_in};
            prev_q <= cur;
        end
    end

    always_comb begin
        edge_vec = cfg_falling ? (prev_q & ~cur) : (cur & ~prev_q);
    end

endmodule

// File: rtl/gpio_trigger_sequencer.sv
// Multi-channel re-armable delayed trigger. An event (selected edge on a
// masked pin, or soft_trig) seen while ARMED starts a delay; the trigger
// then pulses for pulse_width cycles, or latches high when pulse_width = 0.
//   aclk, aresetn            : clock, async active-low reset
//   gpio_data                : GPIO pins (observed only)
//   cfg_mask/cfg_falling     : pin enables / edge polarity
//   cfg_rearm                : return to ARMED after a pulse
//   delay, pulse_width       : captured at the event
//   arm, disarm, soft_trig   : control requests
//   trigger, armed, busy     : outputs decoded from state / registered
//   overrun, trig_count      : sticky overrun flag, emitted trigger count
//
// state | meaning
// IDLE  | waiting for arm, events ignored
// ARMED | waiting for an event
// DELAY | counting dly_cnt down to 0
// PULSE | trigger high, counting pw_cnt down to 1
// HOLD  | trigger latched high until disarm
module gpio_trigger_sequencer
    import gpio_trig_pkg::*;
#(
    parameter int GPIO_DATA_WIDTH = DEF_GPIO_DATA_WIDTH,
    parameter int DELAY_WIDTH     = DEF_DELAY_WIDTH,
    parameter int PW_WIDTH        = DEF_PW_WIDTH,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    inout  wire  [GPIO_DATA_WIDTH-1:0] gpio_data,
    input  logic [GPIO_DATA_WIDTH-1:0] cfg_mask,
    input  logic                       cfg_falling,
    input  logic                       cfg_rearm,
    input  logic [DELAY_WIDTH-1:0]     delay,
    input  logic [PW_WIDTH-1:0]        pulse_width,
    input  logic                       arm,
    input  logic                       disarm,
    input  logic                       soft_trig,
    output logic                       trigger,
    output logic                       armed,
    output logic                       busy,
    output logic                       overrun,
    output logic [31:0]                trig_count
);

    trig_state_t                state_q, state_d;
    logic [DELAY_WIDTH-1:0]     dly_cnt_q, dly_cnt_d;
    logic [PW_WIDTH-1:0]        pw_cnt_q, pw_cnt_d;
    logic                       trigger_d;
    logic                       overrun_d;
    logic [31:0]                trig_count_d;
    logic [GPIO_DATA_WIDTH-1:0] edge_vec;
    logic                       event_hit;

    gpio_edge_detect #(
        .GPIO_DATA_WIDTH (GPIO_DATA_WIDTH),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_edge (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .gpio_data   (gpio_data),
        .cfg_falling (cfg_falling),
        .edge_vec    (edge_vec)
    );

    assign event_hit = (|(edge_vec & cfg_mask)) | soft_trig;
    assign armed     = (state_q == ST_ARMED);
    assign busy      = (state_q == ST_DELAY) || (state_q == ST_PULSE) ||
                       (state_q == ST_HOLD);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            dly_cnt_q  <= '0;
            pw_cnt_q   <= '0;
            trigger    <= 1'b0;
            overrun    <= 1'b0;
            trig_count <= '0;
        end else begin
            state_q    <= state_d;
            dly_cnt_q  <= dly_cnt_d;
            pw_cnt_q   <= pw_cnt_d;
            trigger    <= trigger_d;
            overrun    <= overrun_d;
            trig_count <= trig_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dly_cnt_d    = dly_cnt_q;
        pw_cnt_d     = pw_cnt_q;
        trigger_d    = trigger;
        overrun_d    = overrun;
        trig_count_d = trig_count;

        if (event_hit && busy) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (arm && !disarm) begin
                    state_d   = ST_ARMED;
                    overrun_d = 1'b0;
                end
            end
            ST_ARMED: begin
                if (event_hit) begin
                    state_d   = ST_DELAY;
                    dly_cnt_d = delay;
                    pw_cnt_d  = pulse_width;
                end
            end
            ST_DELAY: begin
                if (dly_cnt_q == '0) begin
                    state_d      = (pw_cnt_q == '0) ? ST_HOLD : ST_PULSE;
                    trigger_d    = 1'b1;
                    trig_count_d = trig_count + 32'd1;
                end else begin
                    dly_cnt_d = dly_cnt_q - DELAY_WIDTH'(1);
                end
            end
            ST_PULSE: begin
                // Trigger went high on entry, so clearing at 1 gives
                // exactly pulse_width high cycles.
                if (pw_cnt_q == PW_WIDTH'(1)) begin
                    trigger_d = 1'b0;
                    pw_cnt_d  = '0;
                    state_d   = cfg_rearm ? ST_ARMED : ST_IDLE;
                end else begin
                    pw_cnt_d = pw_cnt_q - PW_WIDTH'(1);
                end
            end
            ST_HOLD: begin
                trigger_d = 1'b1;
            end
            default: begin
                state_d   = ST_IDLE;
                trigger_d = 1'b0;
            end
        endcase

        if (disarm) begin
            state_d   = ST_IDLE;
            trigger_d = 1'b0;
            dly_cnt_d = '0;
            pw_cnt_d  = '0;
        end
    end

endmodule

// File: tb/tb_gpio_trigger_sequencer.sv
module tb_gpio_trigger_sequencer;

    localparam int W   = 16;
    localparam int DW  = 32;
    localparam int PWW = 16;
    localparam int S   = 2;

    logic           aclk = 1'b0;
    logic           aresetn = 1'b0;
    wire  [W-1:0]   gpio_data;
    logic [W-1:0]   gpio_drv;
    logic [W-1:0]   cfg_mask;
    logic           cfg_falling;
    logic           cfg_rearm;
    logic [DW-1:0]  delay;
    logic [PWW-1:0] pulse_width;
    logic           arm;
    logic           disarm;
    logic           soft_trig;
    logic           trigger;
    logic           armed;
    logic           busy;
    logic           overrun;
    logic [31:0]    trig_count;

    int n_chk  = 0;
    int n_pass = 0;

    assign gpio_data = gpio_drv;

    always #5 aclk = ~aclk;

    gpio_trigger_sequencer #(
        .GPIO_DATA_WIDTH (W),
        .DELAY_WIDTH     (DW),
        .PW_WIDTH        (PWW),
        .SYNC_STAGES     (S)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .gpio_data   (gpio_data),
        .cfg_mask    (cfg_mask),
        .cfg_falling (cfg_falling),
        .cfg_rearm   (cfg_rearm),
        .delay       (delay),
        .pulse_width (pulse_width),
        .arm         (arm),
        .disarm      (disarm),
        .soft_trig   (soft_trig),
        .trigger     (trigger),
        .armed       (armed),
        .busy        (busy),
        .overrun     (overrun),
        .trig_count  (trig_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: pins reach the sequencer S cycles late; an accepted
    // event schedules the trigger window [start, end) in absolute cycles.
    logic [W-1:0] hist [64];
    longint       cyc     = 100;
    int           m_mode  = 0;   // 0 idle, 1 armed, 2 busy
    longint       t_start = 0;
    longint       t_end   = 0;
    logic         m_ovr   = 1'b0;
    logic         m_trig  = 1'b0;
    logic [31:0]  m_cnt   = '0;

    always @(posedge aclk or negedge aresetn) begin
        logic [W-1:0] cur;
        logic [W-1:0] prv;
        logic [W-1:0] edges;
        logic         ev;
        longint       d;
        longint       p;
        if (!aresetn) begin
            for (int i = 0; i < 64; i++) hist[i] = '0;
            m_mode = 0;
            m_ovr  = 1'b0;
            m_cnt  = '0;
            m_trig = 1'b0;
        end else begin
            cur   = hist[int'((cyc - S) % 64)];
            prv   = hist[int'((cyc - S - 1) % 64)];
            edges = cfg_falling ? (prv & ~cur) : (cur & ~prv);
            ev    = (|(edges & cfg_mask)) || soft_trig;
            if (m_mode == 2 && ev) m_ovr = 1'b1;
            if (disarm) begin
                m_mode = 0;
            end else begin
                case (m_mode)
                    0: if (arm) begin m_mode = 1; m_ovr = 1'b0; end
                    1: if (ev) begin
                        d = delay;
                        p = pulse_width;
                        m_mode  = 2;
                        t_start = cyc + 1 + d;
                        if (p == 0) t_end = -1;
                        else        t_end = t_start + p;
                    end
                    default: begin
                        if (cyc == t_start) m_cnt = m_cnt + 1;
                        if (cyc == t_end)   m_mode = cfg_rearm ? 1 : 0;
                    end
                endcase
            end
            m_trig = (m_mode == 2) && (cyc >= t_start);
            hist[int'(cyc % 64)] = gpio_data;
            cyc++;
        end
    end

    always @(negedge aclk) begin
        chk("model trigger", 32'(trigger), 32'(m_trig));
        chk("model armed", 32'(armed), 32'(m_mode == 1));
        chk("model busy", 32'(busy), 32'(m_mode == 2));
        chk("model overrun", 32'(overrun), 32'(m_ovr));
        chk("model trig_count", trig_count, m_cnt);
    end

    task automatic step(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic do_arm();
        arm = 1'b1; step(1); arm = 1'b0;
    endtask

    task automatic do_disarm();
        disarm = 1'b1; step(1); disarm = 1'b0;
    endtask

    task automatic do_soft();
        soft_trig = 1'b1; step(1); soft_trig = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        gpio_drv = 16'h0004; cfg_mask = '0; cfg_falling = 1'b0; cfg_rearm = 1'b0;
        delay = '0; pulse_width = '0; arm = 1'b0; disarm = 1'b0; soft_trig = 1'b0;
        aresetn = 1'b0;
        step(3);
        aresetn = 1'b1;
        step(2);
        chk("reset trigger", 32'(trigger), 32'd0);
        chk("reset armed", 32'(armed), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset overrun", 32'(overrun), 32'd0);
        chk("reset count", trig_count, 32'd0);

        // soft trigger, delay 5, width 3, one-shot
        delay = 32'd5; pulse_width = 16'd3;
        do_arm();
        chk("t1 armed", 32'(armed), 32'd1);
        do_soft();
        step(5); chk("t1 before rise", 32'(trigger), 32'd0);
        step(1); chk("t1 rise", 32'(trigger), 32'd1);
        step(2); chk("t1 last high", 32'(trigger), 32'd1);
        step(1); chk("t1 fall", 32'(trigger), 32'd0);
        chk("t1 count", trig_count, 32'd1);
        chk("t1 one-shot idle", 32'(armed), 32'd0);

        // falling edge on masked pin 2, unmasked pin 0 rises
        cfg_mask = 16'h0004; cfg_falling = 1'b1; delay = 32'd3; pulse_width = 16'd2;
        do_arm();
        gpio_drv = 16'h0001;
        step(6); chk("t2 before rise", 32'(trigger), 32'd0);
        step(1); chk("t2 rise", 32'(trigger), 32'd1);
        step(2); chk("t2 fall", 32'(trigger), 32'd0);
        chk("t2 count", trig_count, 32'd2);
        do_arm();
        gpio_drv = 16'h0000;
        step(8);
        chk("t2 masked pin ignored", 32'(armed), 32'd1);
        chk("t2 masked count", trig_count, 32'd2);
        cfg_falling = 1'b0;
        gpio_drv = 16'h0004;
        step(10);
        chk("t2 rising count", trig_count, 32'd3);

        // re-arm, delay 0, width 1, four events 10 cycles apart
        cfg_mask = '0; cfg_rearm = 1'b1; delay = '0; pulse_width = 16'd1;
        do_arm();
        for (int i = 0; i < 4; i++) begin
            do_soft();
            if (i == 0) begin
                step(1); chk("t3 one-cycle high", 32'(trigger), 32'd1);
                step(1); chk("t3 low again", 32'(trigger), 32'd0);
                chk("t3 rearmed", 32'(armed), 32'd1);
                step(7);
            end else begin
                step(9);
            end
        end
        chk("t3 count", trig_count, 32'd7);
        do_disarm();
        chk("t3 disarmed", 32'(armed), 32'd0);

        // latched trigger, then disarm; arm+disarm together
        cfg_rearm = 1'b0; delay = 32'd2; pulse_width = '0;
        do_arm();
        do_soft();
        step(10);
        chk("t4 latched", 32'(trigger), 32'd1);
        chk("t4 busy", 32'(busy), 32'd1);
        chk("t4 count", trig_count, 32'd8);
        do_disarm();
        chk("t4 disarm trigger", 32'(trigger), 32'd0);
        chk("t4 disarm busy", 32'(busy), 32'd0);
        arm = 1'b1; disarm = 1'b1; step(1); arm = 1'b0; disarm = 1'b0;
        chk("t4 disarm wins", 32'(armed), 32'd0);

        // overrun, arm clears it; maximum delay does not wrap
        delay = 32'd8; pulse_width = 16'd2;
        do_arm();
        do_soft();
        step(3);
        do_soft();
        chk("t5 overrun set", 32'(overrun), 32'd1);
        step(20);
        chk("t5 single trigger", trig_count, 32'd9);
        chk("t5 idle", 32'(armed), 32'd0);
        chk("t5 overrun sticky", 32'(overrun), 32'd1);
        do_arm();
        chk("t5 arm clears overrun", 32'(overrun), 32'd0);
        delay = 32'hFFFF_FFFF;
        do_soft();
        step(40);
        chk("t5 max delay busy", 32'(busy), 32'd1);
        chk("t5 max delay no trigger", 32'(trigger), 32'd0);
        do_disarm();
        chk("t5 max delay disarm", 32'(busy), 32'd0);

        // async reset while latched
        delay = '0; pulse_width = '0;
        do_arm();
        do_soft();
        step(3);
        chk("t6 latched", 32'(trigger), 32'd1);
        #2 aresetn = 1'b0;
        #1 chk("t6 reset trigger", 32'(trigger), 32'd0);
        chk("t6 reset busy", 32'(busy), 32'd0);
        chk("t6 reset count", trig_count, 32'd0);
        step(3);
        aresetn = 1'b1;
        do_soft();
        step(10);
        chk("t6 no trigger without arm", 32'(trigger), 32'd0);
        chk("t6 count", trig_count, 32'd0);

        // async reset mid-DELAY
        delay = 32'd20; pulse_width = 16'd4;
        do_arm();
        do_soft();
        step(5);
        chk("t7 in delay", 32'(busy), 32'd1);
        #2 aresetn = 1'b0;
        #1 chk("t7 reset trigger", 32'(trigger), 32'd0);
        chk("t7 reset busy", 32'(busy), 32'd0);
        chk("t7 reset armed", 32'(armed), 32'd0);
        step(2);
        aresetn = 1'b1;
        do_soft();
        step(30);
        chk("t7 no trigger after release", 32'(trigger), 32'd0);
        chk("t7 count", trig_count, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
